// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the instruction-cycle controller:
// FSM state encoding, opcode values and the last-execute-step table.
package cpu_ctrl_pkg;

  localparam int T_W = 8;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DEC   = 3'd1,
    S_IND   = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  // Timing index at which the given opcode finishes and clears the counter.
  function automatic logic [2:0] last_step(input logic [2:0] op);
    logic [2:0] ls;
    case (op)
      OP_AND, OP_ADD, OP_LDA: ls = 3'd5;
      OP_STA, OP_BUN:         ls = 3'd4;
      OP_BSA:                 ls = 3'd5;
      OP_ISZ:                 ls = 3'd6;
      default:                ls = 3'd3;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/instr_cycle_ctrl_if.sv
// Bundle between the sequence counter / datapath and the instruction-cycle
// controller. The controller uses the master modport.
interface instr_cycle_ctrl_if #(parameter int CNT_W = 16);
  import cpu_ctrl_pkg::*;

  logic [T_W-1:0]   timing;
  logic [2:0]       ir_op;
  logic             ir_i;
  logic             halt_req;
  logic             run;
  logic             sc_clr;
  logic             ar_ld_pc;
  logic             ir_ld;
  logic             pc_inr;
  logic             ar_ld_ir;
  logic             ar_ld_mem;
  logic             exec_en;
  logic [2:0]       exec_step;
  logic             halted;
  logic             seq_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  timing, ir_op, ir_i, halt_req, run,
    output sc_clr, ar_ld_pc, ir_ld, pc_inr, ar_ld_ir, ar_ld_mem,
           exec_en, exec_step, halted, seq_err, instr_count
  );

  modport slave (
    output timing, ir_op, ir_i, halt_req, run,
    input  sc_clr, ar_ld_pc, ir_ld, pc_inr, ar_ld_ir, ar_ld_mem,
           exec_en, exec_step, halted, seq_err, instr_count
  );

endinterface

// File: rtl/instr_cycle_ctrl_onehot_enc8.sv
// 8-bit one-hot to 3-bit index encoder; valid_onehot is high only when
// exactly one input bit is set.
module onehot_enc8 (
  input  logic [7:0] onehot,
  output logic [2:0] idx,
  output logic       valid_onehot
);

  always_comb begin
    idx = '0;
    for (int k = 0; k < 8; k++) begin
      if (onehot[k]) idx = idx | 3'(k);
    end
    valid_onehot = (onehot != 8'd0) && ((onehot & (onehot - 8'd1)) == 8'd0);
  end

endmodule

// File: rtl/instr_cycle_ctrl.sv
// Instruction-cycle controller: steps fetch/decode/indirect/execute off the
// sequence counter's one-hot timing word. Optional checker: SEQ_CHECK_EN.
module instr_cycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input logic               clk,
  input logic               reset_n,
  instr_cycle_ctrl_if.master bus
);

  logic [2:0]       step;
  logic             onehot_ok;
  state_t           state, state_nx;
  logic [2:0]       op_q, op_nx;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  logic       sc_clr_c, ar_ld_pc_c, ir_ld_c, pc_inr_c, ar_ld_ir_c, ar_ld_mem_c;
  logic       exec_en_c, halted_c;
  logic [2:0] exec_step_c;

  onehot_enc8 u_enc (
    .onehot       (bus.timing),
    .idx          (step),
    .valid_onehot (onehot_ok)
  );

`ifdef SEQ_CHECK_EN
  logic [2:0] exp_q;
  logic       seq_err_q;
  logic       err;

  assign err = (state != S_ERR) && (!onehot_ok || (step != exp_q));
`endif

  always_comb begin
    state_nx    = state;
    op_nx       = op_q;
    retire      = 1'b0;
    sc_clr_c    = 1'b0;
    ar_ld_pc_c  = 1'b0;
    ir_ld_c     = 1'b0;
    pc_inr_c    = 1'b0;
    ar_ld_ir_c  = 1'b0;
    ar_ld_mem_c = 1'b0;
    exec_en_c   = 1'b0;
    exec_step_c = 3'd0;
    halted_c    = 1'b0;

    // A zero or multi-hot timing word produces no strobe and holds state.
    case (state)
      S_FETCH: begin
        if (onehot_ok && step == 3'd0) begin
          ar_ld_pc_c = 1'b1;
        end else if (onehot_ok && step == 3'd1) begin
          ir_ld_c  = 1'b1;
          pc_inr_c = 1'b1;
          state_nx = S_DEC;
        end
      end
      S_DEC: begin
        if (onehot_ok && step == 3'd2) begin
          ar_ld_ir_c = 1'b1;
          op_nx      = bus.ir_op;
          if (bus.ir_op == OP_REG)  state_nx = S_EXEC;
          else if (bus.ir_i)        state_nx = S_IND;
          else                      state_nx = S_EXEC;
        end
      end
      S_IND: begin
        if (onehot_ok && step == 3'd3) begin
          ar_ld_mem_c = 1'b1;
          state_nx    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (onehot_ok) begin
          exec_en_c   = 1'b1;
          exec_step_c = step;
          if (step == last_step(op_q)) begin
            sc_clr_c = 1'b1;
            retire   = 1'b1;
            state_nx = bus.halt_req ? S_HALT : S_FETCH;
          end
        end
      end
      S_HALT: begin
        halted_c = 1'b1;
        // The run cycle doubles as the fetch T0 of the next instruction.
        if (bus.run) begin
          ar_ld_pc_c = 1'b1;
          state_nx   = S_FETCH;
        end else begin
          sc_clr_c = 1'b1;
        end
      end
`ifdef SEQ_CHECK_EN
      S_ERR: begin
        sc_clr_c = 1'b1;
      end
`endif
      default: begin
        state_nx = S_FETCH;
      end
    endcase

`ifdef SEQ_CHECK_EN
    if (err) begin
      state_nx    = S_ERR;
      op_nx       = op_q;
      retire      = 1'b0;
      sc_clr_c    = 1'b0;
      ar_ld_pc_c  = 1'b0;
      ir_ld_c     = 1'b0;
      pc_inr_c    = 1'b0;
      ar_ld_ir_c  = 1'b0;
      ar_ld_mem_c = 1'b0;
      exec_en_c   = 1'b0;
      exec_step_c = 3'd0;
      halted_c    = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_FETCH;
      op_q  <= '0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      op_q  <= op_nx;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef SEQ_CHECK_EN
  // Expected step restarts at T0 after every counter clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_q     <= 3'd0;
      seq_err_q <= 1'b0;
    end else begin
      exp_q     <= sc_clr_c ? 3'd0 : 3'(step + 3'd1);
      seq_err_q <= seq_err_q | err;
    end
  end

  assign bus.seq_err = seq_err_q;
`else
  assign bus.seq_err = 1'b0;
`endif

  // Strobes are forced low for the whole time reset is asserted.
  assign bus.sc_clr      = reset_n & sc_clr_c;
  assign bus.ar_ld_pc    = reset_n & ar_ld_pc_c;
  assign bus.ir_ld       = reset_n & ir_ld_c;
  assign bus.pc_inr      = reset_n & pc_inr_c;
  assign bus.ar_ld_ir    = reset_n & ar_ld_ir_c;
  assign bus.ar_ld_mem   = reset_n & ar_ld_mem_c;
  assign bus.exec_en     = reset_n & exec_en_c;
  assign bus.exec_step   = reset_n ? exec_step_c : 3'd0;
  assign bus.halted      = reset_n & halted_c;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_instr_cycle_ctrl.sv
// Scoreboard bench for instr_cycle_ctrl driven by a sequence-counter model;
// builds the SEQ_CHECK_EN injection case when that macro is defined.
module tb_instr_cycle_ctrl;
  import cpu_ctrl_pkg::*;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  instr_cycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  instr_cycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Sequence counter: counts T0..T7, cleared synchronously by sc_clr.
  logic [2:0] sc;
  logic       inject = 1'b0;
  logic [7:0] inj_word = 8'b0000_0110;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        sc <= 3'd0;
    else if (bus.sc_clr) sc <= 3'd0;
    else                 sc <= sc + 3'd1;
  end

  always_comb bus.timing = inject ? inj_word : (8'd1 << sc);

  typedef struct packed {
    logic             sc_clr;
    logic             ar_ld_pc;
    logic             ir_ld;
    logic             pc_inr;
    logic             ar_ld_ir;
    logic             ar_ld_mem;
    logic             exec_en;
    logic [2:0]       exec_step;
    logic             halted;
    logic             seq_err;
    logic [CNT_W-1:0] count;
  } obs_t;

  obs_t exp_q[$];
  int   tag_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Reference model state: retired count, sticky error, where the next
  // instruction starts (1 after a run cycle that already served as T0).
  logic [CNT_W-1:0] m_cnt = '0;
  logic             m_err = 1'b0;
  int               next_t0 = 0;
  int               last_tbl [8] = '{5, 5, 5, 4, 4, 5, 6, 3};

  function automatic obs_t expect_instr(input int op, input bit ii, input int t);
    obs_t e;
    bit   ind;
    e = '0;
    ind = ii && (op != 7);
    e.ar_ld_pc  = (t == 0);
    e.ir_ld     = (t == 1);
    e.pc_inr    = (t == 1);
    e.ar_ld_ir  = (t == 2);
    e.ar_ld_mem = ind && (t == 3);
    e.exec_en   = (t >= 3) && !(ind && t == 3);
    e.exec_step = e.exec_en ? 3'(t) : 3'd0;
    e.sc_clr    = (t == last_tbl[op]);
    e.seq_err   = m_err;
    e.count     = m_cnt;
    return e;
  endfunction

  function automatic obs_t halt_obs(input bit rn);
    obs_t e;
    e = '0;
    e.halted   = 1'b1;
    e.sc_clr   = !rn;
    e.ar_ld_pc = rn;
    e.count    = m_cnt;
    return e;
  endfunction

  task automatic tick(input logic rv, input logic [2:0] op, input logic ii,
                      input logic hr, input logic rn, input logic inj, input obs_t e);
    @(posedge clk);
    #1;
    reset_n      = rv;
    bus.ir_op    = op;
    bus.ir_i     = ii;
    bus.halt_req = hr;
    bus.run      = rn;
    inject       = inj;
    exp_q.push_back(e);
    tag_q.push_back(cyc);
    cyc++;
  endtask

  task automatic do_instr(input int op, input bit ii, input bit hreq,
                          input int hold, input int abort_t);
    int         last;
    logic [2:0] opd;
    logic       idd;
    logic       hr;
    last = last_tbl[op];
    for (int t = next_t0; t <= last; t++) begin
      if (t == abort_t) begin
        m_cnt = '0;
        m_err = 1'b0;
        repeat (3) tick(1'b0, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0, 1'b0, '0);
        next_t0 = 0;
        return;
      end
      opd = (t < 2) ? 3'($urandom_range(0, 7)) : 3'(op);
      idd = (t < 2) ? 1'($urandom_range(0, 1)) : ii;
      hr  = (t == last) ? hreq : ($urandom_range(0, 3) == 0);
      tick(1'b1, opd, idd, hr, 1'b0, 1'b0, expect_instr(op, ii, t));
      if (t == last) m_cnt = m_cnt + 1'b1;
    end
    next_t0 = 0;
    if (hreq) begin
      for (int k = 0; k < hold; k++)
        tick(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0, 1'b0, halt_obs(1'b0));
      tick(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)),
           1'b1, 1'b0, halt_obs(1'b1));
      next_t0 = 1;
    end
  endtask

  obs_t act, want;
  int   tg;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      tg   = tag_q.pop_front();
      act  = {bus.sc_clr, bus.ar_ld_pc, bus.ir_ld, bus.pc_inr, bus.ar_ld_ir,
              bus.ar_ld_mem, bus.exec_en, bus.exec_step, bus.halted,
              bus.seq_err, bus.instr_count};
      n_chk++;
      if (act !== want) begin
        n_fail++;
        $display("FAIL outputs cycle%0d: got %h required %h", tg, act, want);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t e;
    bus.ir_op    = 3'd0;
    bus.ir_i     = 1'b0;
    bus.halt_req = 1'b0;
    bus.run      = 1'b0;

    repeat (3) tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    do_instr(1, 1'b0, 1'b0, 0, -1);
    do_instr(2, 1'b1, 1'b0, 0, -1);
    do_instr(7, 1'b0, 1'b0, 0, -1);
    do_instr(6, 1'b0, 1'b0, 0, -1);
    do_instr(3, 1'b0, 1'b0, 0, -1);
    do_instr(4, 1'b0, 1'b1, 5, -1);

    for (int n = 0; n < 40; n++)
      do_instr($urandom_range(0, 7), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 4) == 0), $urandom_range(1, 4), -1);

    do_instr(6, 1'b0, 1'b0, 0, 4);
    do_instr(0, 1'b1, 1'b0, 0, -1);
    do_instr(5, 1'b0, 1'b0, 0, -1);

`ifdef SEQ_CHECK_EN
    tick(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, expect_instr(1, 1'b0, 0));
    e = '0;
    e.count = m_cnt;
    tick(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, e);
    m_err = 1'b1;
    repeat (4) begin
      e = '0;
      e.sc_clr  = 1'b1;
      e.seq_err = 1'b1;
      e.count   = m_cnt;
      tick(1'b1, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, e);
    end
    m_err = 1'b0;
    m_cnt = '0;
    repeat (2) tick(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    next_t0 = 0;
    do_instr(1, 1'b0, 1'b0, 0, -1);
`else
    e = '0;
`endif

    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_cycle_ctrl.md
Name: instr_cycle_ctrl

Overview:
- Consumer/controller end of the sequence-counter interface.
- Takes the one-hot timing word T[7:0] from the sequence counter and the IR opcode/indirect bit.
- Steps fetch -> decode -> (indirect) -> execute, and emits per-step control strobes.
- Drives the counter's clear (`sc_clr`) to end each instruction cycle. Also provides halt/run, a retired-instruction count, and an optional sequence checker.

Parameters:
- CNT_W, 16, width of retired-instruction counter
- T_W, 8, width of one-hot timing word (fixed 8; log2 = 3)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- timing  in  8  one-hot T0..T7 from sequence counter
- ir_op  in  3  opcode, valid from T2 onward
- ir_i  in  1  indirect bit, valid from T2 onward
- halt_req  in  1  request halt at end of current instruction
- run  in  1  leave HALT
- sc_clr  out  1  synchronous clear to sequence counter
- ar_ld_pc  out  1  fetch T0 strobe
- ir_ld  out  1  fetch T1 strobe
- pc_inr  out  1  fetch T1 strobe
- ar_ld_ir  out  1  decode T2 strobe
- ar_ld_mem  out  1  indirect T3 strobe
- exec_en  out  1  execute-step valid
- exec_step  out  3  encoded T index during execute, else 0
- halted  out  1  in HALT
- seq_err  out  1  sticky sequence error
- instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset and interface timing:
  - Asynchronous active-low reset: `clk` and `reset_n`, as fixed above.
  - While `reset_n`=0: state=S_FETCH, exp=0, instr_count=0, seq_err=0, all outputs 0.
  - The counter clears synchronously, so `sc_clr` asserted in the cycle showing Tk makes the next cycle show T0.
- Step encoding: step = index of the set bit of `timing`. All strobes are combinational from registered state plus the current `timing` (zero latency, aligned to the T cycle). Registered: state, exp, instr_count, seq_err.
- States and transitions:
  - S_FETCH:
    - T0 -> `ar_ld_pc`.
    - T1 -> `ir_ld`, `pc_inr`, then next state S_DEC.
  - S_DEC:
    - T2 -> `ar_ld_ir`.
    - Next state: S_EXEC if ir_op=7; else S_IND if ir_i=1; else S_EXEC.
    - Both opcode and indirect bit are latched into state at T2.
  - S_IND: T3 -> `ar_ld_mem`, then next state S_EXEC.
  - S_EXEC:
    - `exec_en`=1 and `exec_step`=step.
    - Execution spans T3 (op 7 and direct memory-reference) or T4 onward, ending at `LAST_STEP[op]`.
    - At the last step: `sc_clr`=1, `instr_count`+1, next state S_FETCH, or S_HALT if `halt_req`=1 in that cycle.
  - S_HALT:
    - `halted`=1, `sc_clr`=1 every cycle (counter held at T0), no strobes.
    - `run`=1 -> the cycle is the fetch T0: `sc_clr`=0, `ar_ld_pc`=1, next state S_FETCH.
    - `run` has priority over `halt_req`.
  - S_ERR (checker only): `sc_clr`=1 continuously, all strobes 0; exits only via reset.
- `LAST_STEP` table:
  - op0 AND, op1 ADD, op2 LDA: T5
  - op3 STA: T4
  - op4 BUN: T4
  - op5 BSA: T5
  - op6 ISZ: T6
  - op7 reg/IO: T3
- Direct memory-reference ops idle T3 with `exec_en`=1 and no other strobe.
- `instr_count` wraps from all-ones to 0. It does not increment in HALT hold cycles.
- Reset mid-instruction: immediate return to S_FETCH, exp=0, count cleared.

Optional Feature:
- Macro: SEQ_CHECK_EN.
- Defined:
  - Every cycle outside reset, flag an error if `timing` is not exactly one-hot, or if step != exp.
  - exp = 0 after reset, after any `sc_clr` cycle, and in HALT; otherwise exp = step+1.
  - On error: `seq_err` is set sticky and the FSM goes to S_ERR.
- Undefined: `seq_err` tied 0, no S_ERR, FSM trusts `timing` (zero or multi-hot word treated as no strobe, state held).

Decomposition:
- Package `cpu_ctrl_pkg`:
  - State enum.
  - Opcode constants OP_AND..OP_REG.
  - `LAST_STEP` lookup function.
  - T_W.
- One sub-module `onehot_enc8`: 8-bit one-hot -> 3-bit index plus `valid_onehot` flag.

Test Plan:
- ADD direct (op1, i=0), T0..T5 driven by the real counter:
  - `ar_ld_pc`@T0; `ir_ld`/`pc_inr`@T1; `ar_ld_ir`@T2.
  - `exec_en` T3..T5 with `exec_step` 3,4,5.
  - `sc_clr`@T5 only; next cycle T0; instr_count=1.
- LDA indirect (op2, i=1): `ar_ld_mem`@T3 only; `sc_clr`@T5; no `exec_en` at T3.
- Back-to-back op7, op6, op3:
  - `sc_clr` at T3, T6, T4 respectively.
  - instr_count 3; no gap cycles between instructions.
- `halt_req`=1 at the last step of BUN:
  - `halted`=1 and `sc_clr`=1 held for 5 cycles.
  - `run` pulse -> same-cycle `ar_ld_pc`=1 and `sc_clr`=0; fetch resumes at T1.
- SEQ_CHECK_EN, inject `timing`=8'b0000_0110 at T1 or skip T2->T4: `seq_err`=1 next cycle, `sc_clr` stuck 1, strobes 0 until `reset_n` low.
- Assert `reset_n` low mid-T4 of ISZ: all outputs 0 immediately, count 0; after release plus counter clear, fetch restarts at T0.
